monitor_event_scheduler: RTL

Timestamped event injector in front of the generated RTLola monitor `topEntity`. It buffers `(timestamp, value)` events from a host/stimulus source and keeps a free-running cycle-time counter. When an event's time arrives, it drives the monitor's `input_0` / `new_input_0` pair as a single-cycle strobe. It replaces hand-written `@(posedge clk)` injection sequences and enforces the monitor's minimum inter-event spacing.

---
 rtl/monitor_sched_pkg.sv | 23 ++
 rtl/sched_fifo.sv | 67 ++++++
 rtl/monitor_event_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/monitor_sched_pkg.sv
// Shared types and default widths for the monitor event scheduler.
package monitor_sched_pkg;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_TS_W    = 32;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_MIN_GAP = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FIRE,
    GAP
  } sched_state_e;

  // Event record at the default widths; the top re-declares the same
  // layout sized by its own parameters.
  typedef struct packed {
    logic [DEF_TS_W-1:0]          ts;
    logic signed [DEF_DATA_W-1:0] data;
  } sched_event_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO; the head entry is read straight out of the storage
// registers, so a pushed entry becomes visible one cycle later.
module sched_fifo
  import monitor_sched_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset empties the FIFO by clearing pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/monitor_event_scheduler.sv
// Buffers timestamped events and replays each one as a single-cycle
// input_0/new_input_0 strobe when the cycle-time counter reaches it,
// keeping at least MIN_GAP cycles between strobes.
module monitor_event_scheduler
  import monitor_sched_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TS_W    = DEF_TS_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MIN_GAP = DEF_MIN_GAP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic [TS_W-1:0]          ev_ts,
  input  logic signed [DATA_W-1:0] ev_data,
  output logic signed [DATA_W-1:0] input_0,
  output logic                     new_input_0,
  output logic [TS_W-1:0]          time_now,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     late_err,
  output logic                     order_err
);

  typedef struct packed {
    logic [TS_W-1:0]          ts;
    logic signed [DATA_W-1:0] data;
  } ev_t;

  localparam int EV_W = $bits(ev_t);
  localparam int GW   = $clog2(MIN_GAP) + 1;

  sched_state_e             state_q, state_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic [TS_W-1:0]          time_q, time_d;
  logic [TS_W-1:0]          last_ts_q, last_ts_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     new_q, new_d;
  logic                     late_q, late_d;
  logic                     order_q, order_d;

  ev_t                      push_ev, head_ev;
  logic [EV_W-1:0]          head_bits;
  logic                     push, pop, full, empty;

  assign push_ev = '{ts: ev_ts, data: ev_data};
  assign head_ev = ev_t'(head_bits);
  // Ready is held low while reset is asserted; a full FIFO never bypasses.
  assign ev_ready = rst & ~full;
  assign push     = ev_valid & ev_ready;

  sched_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .wdata_i (push_ev),
    .pop_i   (pop),
    .head_o  (head_bits),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  // Strobe is suppressed while disabled; the held FIRE state delivers it later.
  assign new_input_0 = new_q & en;
  assign input_0     = new_input_0 ? data_q : '0;
  assign time_now    = time_q;
  assign late_err    = late_q;
  assign order_err   = order_q;

  // Injection FSM: wait for head timestamp, fire one cycle, then enforce the gap.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    data_d  = data_q;
    new_d   = new_q;
    late_d  = late_q;
    pop     = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (!empty) state_d = WAIT;
        end
        WAIT: begin
          if (empty) begin
            state_d = IDLE;
          end else if (time_q >= head_ev.ts) begin
            pop     = 1'b1;
            data_d  = head_ev.data;
            new_d   = 1'b1;
            state_d = FIRE;
            if (time_q > head_ev.ts) late_d = 1'b1;
          end
        end
        FIRE: begin
          new_d  = 1'b0;
          data_d = '0;
          if (MIN_GAP > 2) begin
            gap_d   = GW'(MIN_GAP - 2);
            state_d = GAP;
          end else begin
            state_d = empty ? IDLE : WAIT;
          end
        end
        GAP: begin
          if (gap_q <= GW'(1)) state_d = empty ? IDLE : WAIT;
          else                 gap_d   = gap_q - GW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Free-running cycle time and the out-of-order timestamp check on push.
  always_comb begin
    time_d    = en ? time_q + TS_W'(1) : time_q;
    order_d   = order_q;
    last_ts_d = last_ts_q;
    if (push) begin
      if (ev_ts < last_ts_q) order_d = 1'b1;
      last_ts_d = ev_ts;
    end
  end

  // State registers; reset drops queued events and any strobe in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      time_q    <= '0;
      last_ts_q <= '0;
      data_q    <= '0;
      new_q     <= 1'b0;
      late_q    <= 1'b0;
      order_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      time_q    <= time_d;
      last_ts_q <= last_ts_d;
      data_q    <= data_d;
      new_q     <= new_d;
      late_q    <= late_d;
      order_q   <= order_d;
    end
  end

endmodule
